// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the PC sequencing controller: widths, FSM encoding,
// default interrupt vector and the next-address bundle.
package pc_seq_ctrl_pkg;

    localparam int unsigned PC_W  = 30;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned OFF_W = 16;
    localparam int unsigned JT_W  = 26;

    localparam logic [PC_W-1:0] IRQ_VEC_DEFAULT = 30'h0000020;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_ISR  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Candidate next addresses produced by the arithmetic block
    typedef struct packed {
        logic [PC_W-1:0] seq;
        logic [PC_W-1:0] br;
        logic [PC_W-1:0] jt;
    } npc_t;

    // Sign-extend a branch word offset to PC width
    function automatic logic [PC_W-1:0] sext_off(input logic [OFF_W-1:0] off);
        return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_npc.sv
// Next-address arithmetic: sequential, branch and jump targets (modulo 2^30).
module npc_calc
    import pc_seq_ctrl_pkg::*;
(
    input  logic [PC_W-1:0]  pcout_i,
    input  logic [OFF_W-1:0] branch_off_i,
    input  logic [JT_W-1:0]  jump_target_i,
    output npc_t             npc_o
);

    logic [PC_W-1:0] seq;

    // Branch target is relative to the sequential address; jump keeps its region bits
    always_comb begin
        seq       = pcout_i + PC_W'(1);
        npc_o.seq = seq;
        npc_o.br  = seq + sext_off(branch_off_i);
        npc_o.jt  = {seq[PC_W-1:JT_W], jump_target_i};
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: selects the next PC each cycle, handles interrupt
// entry/return, halt, and counts retired instructions.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] IRQ_VEC = IRQ_VEC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   pcout,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [OFF_W-1:0]  branch_off,
    input  logic              jump,
    input  logic [JT_W-1:0]   jump_target,
    input  logic              jr,
    input  logic [PC_W-1:0]   jr_target,
    input  logic              irq,
    input  logic              eret,
    input  logic              halt,
    output logic [PC_W-1:0]   newpc,
    output logic [PC_W-1:0]   epc,
    output logic              irq_ack,
    output logic              halted,
    output logic [CNT_W-1:0]  inst_cnt
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  epc_q, epc_d;
    logic             irq_pend_q, irq_pend_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

    npc_t             npc;
    logic [PC_W-1:0]  flow_pc;
    logic             active;
    logic             advance;
    logic             take_irq;
    logic             do_eret;

    npc_calc u_npc_calc (
        .pcout_i       (pcout),
        .branch_off_i  (branch_off),
        .jump_target_i (jump_target),
        .npc_o         (npc)
    );

    // Control-flow target ignoring interrupts: jr > jump > branch > sequential
    always_comb begin
        if (jr) begin
            flow_pc = jr_target;
        end else if (jump) begin
            flow_pc = npc.jt;
        end else if (branch_take) begin
            flow_pc = npc.br;
        end else begin
            flow_pc = npc.seq;
        end
    end

    // Cycle qualifiers shared by the FSM and datapath
    always_comb begin
        active   = (state_q != ST_HALT);
        advance  = active && !stall && !halt;
        take_irq = advance && (state_q == ST_RUN) && irq_pend_q;
        do_eret  = advance && (state_q == ST_ISR) && eret;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; only reset leaves HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (take_irq) begin
                    state_d = ST_ISR;
                end
            end
            ST_ISR: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (do_eret) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM outputs: next-PC select feeds the PC register on the same edge
    always_comb begin
        newpc   = flow_pc;
        irq_ack = 1'b0;
        halted  = (state_q == ST_HALT);
        if (reset) begin
            newpc = '0;
        end else if (!active || halt || stall) begin
            newpc = pcout;
        end else if (take_irq) begin
            newpc   = IRQ_VEC;
            irq_ack = 1'b1;
        end else if (do_eret) begin
            newpc = epc_q;
        end
    end

    // Next values for return address, pending flag and retired count
    always_comb begin
        epc_d      = epc_q;
        irq_pend_d = irq_pend_q;
        inst_cnt_d = inst_cnt_q;
        if (take_irq) begin
            epc_d      = flow_pc;
            irq_pend_d = 1'b0;
        end else if (active && irq) begin
            irq_pend_d = 1'b1;
        end
        if (advance && !take_irq) begin
            inst_cnt_d = inst_cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q      <= '0;
            irq_pend_q <= 1'b0;
            inst_cnt_q <= '0;
        end else begin
            epc_q      <= epc_d;
            irq_pend_q <= irq_pend_d;
            inst_cnt_q <= inst_cnt_d;
        end
    end

    assign epc      = epc_q;
    assign inst_cnt = inst_cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: behavioural model plus directed vectors.
module tb_pc_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [29:0] pcout;
    logic        stall;
    logic        branch_take;
    logic [15:0] branch_off;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [29:0] jr_target;
    logic        irq;
    logic        eret;
    logic        halt;
    logic [29:0] newpc;
    logic [29:0] epc;
    logic        irq_ack;
    logic        halted;
    logic [31:0] inst_cnt;

    int n_run  = 0;
    int n_fail = 0;

    pc_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pcout       (pcout),
        .stall       (stall),
        .branch_take (branch_take),
        .branch_off  (branch_off),
        .jump        (jump),
        .jump_target (jump_target),
        .jr          (jr),
        .jr_target   (jr_target),
        .irq         (irq),
        .eret        (eret),
        .halt        (halt),
        .newpc       (newpc),
        .epc         (epc),
        .irq_ack     (irq_ack),
        .halted      (halted),
        .inst_cnt    (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_in_isr  = 1'b0;
    bit          m_stopped = 1'b0;
    bit          m_pend    = 1'b0;
    logic [29:0] m_epc     = '0;
    logic [31:0] m_cnt     = '0;

    function automatic logic [29:0] flow_target();
        longint s;
        s = longint'(pcout) + 1;
        if (jr) return jr_target;
        if (jump) return (30'(s) & 30'h3C000000) | 30'(jump_target);
        if (branch_take) return 30'(s + longint'($signed(branch_off)));
        return 30'(s);
    endfunction

    function automatic logic [29:0] model_newpc();
        if (reset) return 30'h0;
        if (m_stopped || halt || stall) return pcout;
        if (!m_in_isr && m_pend) return 30'h20;
        if (m_in_isr && eret) return m_epc;
        return flow_target();
    endfunction

    function automatic bit model_ack();
        return !reset && !m_stopped && !halt && !stall && !m_in_isr && m_pend;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_in_isr  <= 1'b0;
            m_stopped <= 1'b0;
            m_pend    <= 1'b0;
            m_epc     <= '0;
            m_cnt     <= '0;
        end else if (!m_stopped) begin
            if (halt) begin
                m_stopped <= 1'b1;
                if (irq) m_pend <= 1'b1;
            end else if (stall) begin
                if (irq) m_pend <= 1'b1;
            end else if (!m_in_isr && m_pend) begin
                m_epc    <= flow_target();
                m_in_isr <= 1'b1;
                m_pend   <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_in_isr && eret) m_in_isr <= 1'b0;
                if (irq) m_pend <= 1'b1;
            end
        end
    end

    // ---------------- hand-computed literal expectations ----------------
    bit          l_np_en,  l_ack_en, l_epc_en, l_cnt_en, l_hlt_en;
    logic [29:0] l_np,     l_epc;
    logic [31:0] l_cnt;
    bit          l_ack,    l_hlt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: model every cycle, literals when armed
    always @(negedge clk) begin
        check("newpc",    32'(newpc),    32'(model_newpc()));
        check("irq_ack",  32'(irq_ack),  32'(model_ack()));
        check("halted",   32'(halted),   32'(!reset && m_stopped));
        check("epc",      32'(epc),      32'(m_epc));
        check("inst_cnt", inst_cnt,      m_cnt);
        if (l_np_en)  check("lit_newpc",    32'(newpc),   32'(l_np));
        if (l_ack_en) check("lit_irq_ack",  32'(irq_ack), 32'(l_ack));
        if (l_epc_en) check("lit_epc",      32'(epc),     32'(l_epc));
        if (l_cnt_en) check("lit_inst_cnt", inst_cnt,     l_cnt);
        if (l_hlt_en) check("lit_halted",   32'(halted),  32'(l_hlt));
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        stall = 0; branch_take = 0; branch_off = '0; jump = 0; jump_target = '0;
        jr = 0; jr_target = '0; irq = 0; eret = 0; halt = 0;
        l_np_en = 0; l_ack_en = 0; l_epc_en = 0; l_cnt_en = 0; l_hlt_en = 0;
    endtask

    task automatic lit_np(input logic [29:0] v);  l_np_en = 1; l_np = v;   endtask
    task automatic lit_ack(input bit v);          l_ack_en = 1; l_ack = v; endtask
    task automatic lit_epc(input logic [29:0] v); l_epc_en = 1; l_epc = v; endtask
    task automatic lit_cnt(input logic [31:0] v); l_cnt_en = 1; l_cnt = v; endtask
    task automatic lit_hlt(input bit v);          l_hlt_en = 1; l_hlt = v; endtask

    initial begin
        reset = 1; pcout = '0; stall = 0; branch_take = 0; branch_off = '0;
        jump = 0; jump_target = '0; jr = 0; jr_target = '0; irq = 0; eret = 0; halt = 0;
        l_np_en = 0; l_ack_en = 0; l_epc_en = 0; l_cnt_en = 0; l_hlt_en = 0;
        l_np = '0; l_epc = '0; l_cnt = '0; l_ack = 0; l_hlt = 0;

        // in reset: newpc forced to 0
        next_cycle(); pcout = 30'h123;
        lit_np(30'h0); lit_cnt(0); lit_hlt(0); lit_epc(0); lit_ack(0);

        // branches backward / forward
        next_cycle(); reset = 0; pcout = 30'h10; branch_take = 1; branch_off = 16'hFFFC;
        lit_np(30'h0D); lit_cnt(0);
        next_cycle(); pcout = 30'h10; branch_take = 1; branch_off = 16'h0005;
        lit_np(30'h16);
        // sequential wrap and jump region
        next_cycle(); pcout = 30'h3FFFFFFF; lit_np(30'h0);
        next_cycle(); pcout = 30'h08000000; jump = 1; jump_target = 26'h0000100;
        lit_np(30'h08000100);
        // priority jr > jump > branch
        next_cycle(); pcout = 30'h100; jr = 1; jr_target = 30'h2222; jump = 1;
        jump_target = 26'h55; branch_take = 1; branch_off = 16'h3;
        lit_np(30'h2222);
        next_cycle(); pcout = 30'h100; jump = 1; jump_target = 26'h55;
        branch_take = 1; branch_off = 16'h3;
        lit_np(30'h55);
        // eret in RUN is ignored
        next_cycle(); pcout = 30'h200; eret = 1; lit_np(30'h201); lit_cnt(6);

        // irq during stall: no entry, then entry on first unstalled cycle
        next_cycle(); pcout = 30'h40; stall = 1; irq = 1; lit_np(30'h40); lit_ack(0);
        next_cycle(); pcout = 30'h40; lit_np(30'h20); lit_ack(1); lit_cnt(7);
        next_cycle(); pcout = 30'h20; irq = 1; lit_np(30'h21); lit_ack(0); lit_epc(30'h41);
        lit_cnt(7);
        next_cycle(); pcout = 30'h21; stall = 1; eret = 1; lit_np(30'h21);
        next_cycle(); pcout = 30'h21; eret = 1; lit_np(30'h41); lit_ack(0);
        // pending irq from ISR re-enters on the next cycle
        next_cycle(); pcout = 30'h41; lit_np(30'h20); lit_ack(1); lit_cnt(9);
        next_cycle(); pcout = 30'h20; lit_epc(30'h42); lit_np(30'h21);
        next_cycle(); pcout = 30'h21; eret = 1; lit_np(30'h42);

        // halt beats jr; HALT ignores inputs and freezes the counter
        next_cycle(); pcout = 30'h42; halt = 1; jr = 1; jr_target = 30'h999;
        lit_np(30'h42); lit_ack(0); lit_cnt(11);
        next_cycle(); pcout = 30'h50; jr = 1; jr_target = 30'h999; irq = 1; eret = 1;
        lit_np(30'h50); lit_hlt(1); lit_cnt(11);
        next_cycle(); pcout = 30'h60; lit_np(30'h60); lit_hlt(1); lit_cnt(11);
        next_cycle(); reset = 1; pcout = 30'h60;
        lit_np(30'h0); lit_hlt(0); lit_cnt(0);
        next_cycle(); reset = 0; pcout = 30'h70; lit_np(30'h71); lit_hlt(0); lit_cnt(0);

        // reset mid-ISR drops the pending interrupt and saved epc
        next_cycle(); pcout = 30'h80; irq = 1; lit_np(30'h81);
        next_cycle(); pcout = 30'h81; lit_np(30'h20); lit_ack(1);
        next_cycle(); pcout = 30'h20; irq = 1; lit_epc(30'h82);
        next_cycle(); reset = 1; pcout = 30'h20; lit_np(30'h0); lit_epc(30'h0);
        next_cycle(); reset = 0; pcout = 30'h90; lit_np(30'h91); lit_ack(0); lit_epc(30'h0);
        next_cycle(); pcout = 30'h90; eret = 1; lit_np(30'h91);

        // mixed traffic checked against the model only
        for (int i = 0; i < 200; i++) begin
            next_cycle();
            pcout       = 30'($urandom);
            stall       = ($urandom_range(0, 3) == 0);
            irq         = ($urandom_range(0, 7) == 0);
            eret        = ($urandom_range(0, 3) == 0);
            jr          = ($urandom_range(0, 5) == 0);
            jr_target   = 30'($urandom);
            jump        = ($urandom_range(0, 4) == 0);
            jump_target = 26'($urandom);
            branch_take = ($urandom_range(0, 2) == 0);
            branch_off  = 16'($urandom);
            halt        = (i == 150);
        end
        next_cycle(); reset = 1;
        next_cycle(); reset = 0; pcout = 30'h3FF; lit_np(30'h400); lit_cnt(0);

        next_cycle();
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter IRQ_VEC, default 30'h0000020, interrupt-vector word address.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pcout  input  30  current PC word address from the PC register.
REQ-005 SHALL have port stall  input  1  hold current PC this cycle.
REQ-006 SHALL have port branch_take  input  1  conditional branch resolved taken.
REQ-007 SHALL have port branch_off  input  16  signed word offset.
REQ-008 SHALL have port jump  input  1  J/JAL.
REQ-009 SHALL have port jump_target  input  26  instr_index.
REQ-010 SHALL have port jr  input  1  JR.
REQ-011 SHALL have port jr_target  input  30  rs[31:2].
REQ-012 SHALL have port irq  input  1  level interrupt request.
REQ-013 SHALL have port eret  input  1  return from interrupt.
REQ-014 SHALL have port halt  input  1  stop fetching.
REQ-015 SHALL have port newpc  output  30  next PC word address to the PC register.
REQ-016 SHALL have port epc  output  30  saved return address.
REQ-017 SHALL have port irq_ack  output  1  one-cycle pulse on interrupt entry.
REQ-018 SHALL have port halted  output  1  high in HALT state.
REQ-019 SHALL have port inst_cnt  output  32  retired-instruction count.

Function
REQ-020 SHALL implement FSM states RUN, ISR and HALT; reset state RUN.
REQ-021 SHALL compute newpc combinationally from pcout, inputs and state, so the PC register updates on the same edge (zero added latency).
REQ-022 SHALL define seq = pcout+1, br = pcout+1+sext(branch_off), jt = {seq[29:26],jump_target}; all arithmetic is modulo 2^30 (30'h3FFFFFFF+1 = 0).
REQ-023 SHALL, in HALT, drive newpc = pcout and ignore all inputs; only reset exits HALT.
REQ-024 SHALL, in RUN/ISR, use this newpc priority: halt → pcout, enter HALT; stall → pcout; irq entry (REQ-025) → IRQ_VEC; eret in ISR → epc; jr → jr_target; jump → jt; branch_take → br; otherwise seq.
REQ-025 SHALL take an interrupt when state=RUN, irq_pend=1, stall=0 and halt=0: epc <= the newpc that would otherwise be selected, irq_ack=1 for that cycle, state <= ISR, irq_pend <= 0.
REQ-026 SHALL set irq_pend on any cycle with irq=1, including during stall and ISR; it is cleared only on entry or by reset.
REQ-027 SHALL treat eret in RUN as a no-op (newpc follows lower priorities); eret in ISR with stall=0 SHALL return to RUN.
REQ-028 SHALL let an irq_pend latched during ISR trigger entry on the first unstalled RUN cycle after eret, never in the same cycle as eret.
REQ-029 SHALL increment inst_cnt on every cycle where state≠HALT, stall=0 and halt=0, wrapping 32'hFFFFFFFF→0; irq-entry cycles do not count.
REQ-030 SHALL, when jr, jump and branch_take assert together, honour priority jr > jump > branch_take.

Reset
REQ-031 SHALL asynchronously clear state to RUN, and epc, irq_pend, inst_cnt, irq_ack and halted to 0 on reset.
REQ-032 SHALL, while reset=1, drive newpc = 0, consistent with the PC register reset value.
REQ-033 SHALL, on reset mid-ISR or in HALT, abandon the saved epc and pending interrupt without further effect.

Structure
REQ-034 SHALL keep state encodings (RUN=2'd0, ISR=2'd1, HALT=2'd2) and the default IRQ_VEC constant in the shared datapath package.
REQ-035 SHALL factor next-address arithmetic (seq, br, jt) into one combinational sub-module npc_calc; the FSM, epc, irq_pend and the counter stay in pc_seq_ctrl.

Verification
REQ-036 SHALL verify: pcout=30'h10, branch_take=1, branch_off=16'hFFFC → newpc=30'h0D; with branch_off=16'h0005 → newpc=30'h16.
REQ-037 SHALL verify: pcout=30'h3FFFFFFF with no control → newpc=0; jump=1, jump_target=26'h0000100 at pcout=30'h08000000 → newpc=30'h08000100.
REQ-038 SHALL verify: irq pulse while stall=1, pcout=30'h40 → newpc=30'h40, no entry; first unstalled cycle → newpc=30'h20, irq_ack=1, epc=30'h41.
REQ-039 SHALL verify: in ISR, irq=1 then eret=1 → newpc=epc, state RUN; next cycle → re-entry with irq_ack=1.
REQ-040 SHALL verify: halt=1 with jr=1 → newpc=pcout, halted=1, inst_cnt frozen; reset → halted=0, inst_cnt=0, newpc=0.
